// File: rtl/btb_pkg.sv
// Shared width helpers and flush FSM encoding for the set-associative BTB.
package btb_pkg;

    function automatic int idx_w(input int num_sets);
        return (num_sets > 1) ? $clog2(num_sets) : 1;
    endfunction

    function automatic int way_w(input int num_ways);
        return (num_ways > 1) ? $clog2(num_ways) : 1;
    endfunction

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_FLUSH = 1'b1
    } flush_state_t;

endpackage

// File: rtl/btb_assoc_if.sv
// Fetch lookup, execute update and flush control bundle of btb_assoc.
interface btb_assoc_if #(
    parameter int NUM_SETS     = 16,
    parameter int NUM_WAYS     = 2,
    parameter int TAG_WIDTH    = 5,
    parameter int TARGET_WIDTH = 32
);
    localparam int IDX_W = btb_pkg::idx_w(NUM_SETS);
    localparam int WAY_W = btb_pkg::way_w(NUM_WAYS);

    logic                    lookup_valid;
    logic [IDX_W-1:0]        lookup_index;
    logic [TAG_WIDTH-1:0]    lookup_tag;
    logic                    hit_valid;
    logic [WAY_W-1:0]        hit_way;
    logic [TARGET_WIDTH-1:0] hit_target;
    logic                    upd_valid;
    logic [IDX_W-1:0]        upd_index;
    logic [TAG_WIDTH-1:0]    upd_tag;
    logic [TARGET_WIDTH-1:0] upd_target;
    logic                    flush_req;
    logic                    flush_busy;

    modport master (
        output lookup_valid, lookup_index, lookup_tag,
        output upd_valid, upd_index, upd_tag, upd_target, flush_req,
        input  hit_valid, hit_way, hit_target, flush_busy
    );

    modport slave (
        input  lookup_valid, lookup_index, lookup_tag,
        input  upd_valid, upd_index, upd_tag, upd_target, flush_req,
        output hit_valid, hit_way, hit_target, flush_busy
    );
endinterface

// File: rtl/btb_repl.sv
// Per-set replacement state: round-robin pointer by default, tree pseudo-LRU
// when BTB_PLRU_EN is defined.
module btb_repl
    import btb_pkg::*;
#(
    parameter int NUM_SETS = 16,
    parameter int NUM_WAYS = 2,
    localparam int IDX_W = idx_w(NUM_SETS),
    localparam int WAY_W = way_w(NUM_WAYS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear_en,
    input  logic [IDX_W-1:0] clear_idx,
    input  logic             touch_en,
    input  logic [IDX_W-1:0] touch_idx,
    input  logic [WAY_W-1:0] touch_way,
    input  logic             upd_en,
    input  logic [IDX_W-1:0] upd_idx,
    input  logic [WAY_W-1:0] upd_way,
    input  logic             upd_victim,
    output logic [WAY_W-1:0] victim_way
);
`ifdef BTB_PLRU_EN
    localparam int LVL = $clog2(NUM_WAYS);
    localparam int RW  = (NUM_WAYS > 1) ? NUM_WAYS - 1 : 1;
`else
    localparam int RW  = WAY_W;
`endif

    logic [RW-1:0] repl_q [NUM_SETS];
    logic [RW-1:0] repl_d [NUM_SETS];

`ifdef BTB_PLRU_EN
    // Heap-ordered tree; each node bit points to the subtree holding the victim.
    function automatic logic [RW-1:0] plru_touch(input logic [RW-1:0] bits,
                                                  input logic [WAY_W-1:0] way);
        logic [RW-1:0] res;
        int node;
        res  = bits;
        node = 0;
        for (int l = 0; l < LVL; l++) begin
            res[node] = ~way[LVL-1-l];
            node      = 2 * node + 1 + int'(way[LVL-1-l]);
        end
        return res;
    endfunction

    function automatic logic [WAY_W-1:0] plru_victim(input logic [RW-1:0] bits);
        logic [WAY_W-1:0] way;
        logic b;
        int node;
        way  = '0;
        node = 0;
        for (int l = 0; l < LVL; l++) begin
            b              = bits[node];
            way[LVL-1-l]   = b;
            node           = 2 * node + 1 + int'(b);
        end
        return way;
    endfunction

    logic unused_victim;
    assign unused_victim = upd_victim;
    assign victim_way    = plru_victim(repl_q[upd_idx]);
`else
    logic unused_touch;
    assign unused_touch = ^{touch_en, touch_idx, touch_way};
    assign victim_way   = repl_q[upd_idx];
`endif

    always_comb begin
        repl_d = repl_q;
`ifdef BTB_PLRU_EN
        if (touch_en) repl_d[touch_idx] = plru_touch(repl_d[touch_idx], touch_way);
        if (upd_en)   repl_d[upd_idx]   = plru_touch(repl_d[upd_idx], upd_way);
`else
        if (upd_en && upd_victim)
            repl_d[upd_idx] = (NUM_WAYS > 1) ? repl_q[upd_idx] + 1'b1 : '0;
`endif
        if (clear_en) repl_d[clear_idx] = '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int s = 0; s < NUM_SETS; s++) repl_q[s] <= '0;
        end else begin
            repl_q <= repl_d;
        end
    end
endmodule

// File: rtl/btb_assoc.sv
// Set-associative branch target buffer with registered lookup, update port and
// multi-cycle flush. Define BTB_PLRU_EN for pseudo-LRU replacement.
module btb_assoc
    import btb_pkg::*;
#(
    parameter int NUM_SETS     = 16,
    parameter int NUM_WAYS     = 2,
    parameter int TAG_WIDTH    = 5,
    parameter int TARGET_WIDTH = 32
) (
    input logic        clk,
    input logic        rst,
    btb_assoc_if.slave bus
);
    localparam int IDX_W = idx_w(NUM_SETS);
    localparam int WAY_W = way_w(NUM_WAYS);

    typedef struct packed {
        logic [TAG_WIDTH-1:0]    tag;
        logic [TARGET_WIDTH-1:0] target;
    } entry_t;

    flush_state_t            state_q, state_d;
    logic [IDX_W-1:0]        flush_cnt_q, flush_cnt_d;
    logic                    flush_busy_q, flush_busy_d;
    logic [NUM_WAYS-1:0]     valid_q [NUM_SETS];
    logic [NUM_WAYS-1:0]     valid_d [NUM_SETS];
    entry_t                  mem [NUM_SETS][NUM_WAYS];
    logic                    hit_valid_q, hit_valid_d;
    logic [WAY_W-1:0]        hit_way_q, hit_way_d;
    logic [TARGET_WIDTH-1:0] hit_target_q, hit_target_d;

    logic                idle, upd_en, lk_hit, upd_has_match, upd_has_free;
    logic [WAY_W-1:0]    lk_way, match_way, free_way, victim_way, upd_way;
    logic [NUM_WAYS-1:0] lk_match, upd_match, upd_free;

    assign idle   = (state_q == ST_IDLE);
    // Updates are dropped while flushing and on the cycle a flush is requested.
    assign upd_en = bus.upd_valid && idle && !bus.flush_req;

    generate
        for (genvar gi = 0; gi < NUM_WAYS; gi++) begin : g_way
            assign lk_match[gi]  = valid_q[bus.lookup_index][gi] &&
                                   (mem[bus.lookup_index][gi].tag == bus.lookup_tag);
            assign upd_match[gi] = valid_q[bus.upd_index][gi] &&
                                   (mem[bus.upd_index][gi].tag == bus.upd_tag);
            assign upd_free[gi]  = !valid_q[bus.upd_index][gi];
        end
    endgenerate

    always_comb begin
        lk_hit        = 1'b0;
        lk_way        = '0;
        upd_has_match = 1'b0;
        match_way     = '0;
        upd_has_free  = 1'b0;
        free_way      = '0;
        for (int w = NUM_WAYS - 1; w >= 0; w--) begin
            if (lk_match[w])  begin lk_hit = 1'b1;        lk_way = WAY_W'(w);    end
            if (upd_match[w]) begin upd_has_match = 1'b1; match_way = WAY_W'(w); end
            if (upd_free[w])  begin upd_has_free = 1'b1;  free_way = WAY_W'(w);  end
        end
        lk_hit  = lk_hit && bus.lookup_valid && idle;
        upd_way = upd_has_match ? match_way : (upd_has_free ? free_way : victim_way);
    end

    always_comb begin
        hit_valid_d  = lk_hit;
        hit_way_d    = lk_hit ? lk_way : '0;
        hit_target_d = lk_hit ? mem[bus.lookup_index][lk_way].target : '0;
        state_d      = state_q;
        flush_cnt_d  = flush_cnt_q;
        valid_d      = valid_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.flush_req) begin
                    state_d     = ST_FLUSH;
                    flush_cnt_d = '0;
                end
            end
            ST_FLUSH: begin
                valid_d[flush_cnt_q] = '0;
                flush_cnt_d          = flush_cnt_q + 1'b1;
                if (flush_cnt_q == IDX_W'(NUM_SETS - 1)) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        if (upd_en) valid_d[bus.upd_index][upd_way] = 1'b1;
        flush_busy_d = (state_d == ST_FLUSH);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            flush_cnt_q  <= '0;
            flush_busy_q <= 1'b0;
            hit_valid_q  <= 1'b0;
            hit_way_q    <= '0;
            hit_target_q <= '0;
            for (int s = 0; s < NUM_SETS; s++) valid_q[s] <= '0;
        end else begin
            state_q      <= state_d;
            flush_cnt_q  <= flush_cnt_d;
            flush_busy_q <= flush_busy_d;
            hit_valid_q  <= hit_valid_d;
            hit_way_q    <= hit_way_d;
            hit_target_q <= hit_target_d;
            valid_q      <= valid_d;
        end
    end

    // Payload needs no reset: it is only observed through a set valid bit.
    always_ff @(posedge clk) begin
        if (upd_en) mem[bus.upd_index][upd_way] <= '{tag: bus.upd_tag, target: bus.upd_target};
    end

    btb_repl #(
        .NUM_SETS (NUM_SETS),
        .NUM_WAYS (NUM_WAYS)
    ) u_repl (
        .clk        (clk),
        .rst        (rst),
        .clear_en   (!idle),
        .clear_idx  (flush_cnt_q),
        .touch_en   (lk_hit),
        .touch_idx  (bus.lookup_index),
        .touch_way  (lk_way),
        .upd_en     (upd_en),
        .upd_idx    (bus.upd_index),
        .upd_way    (upd_way),
        .upd_victim (!upd_has_match && !upd_has_free),
        .victim_way (victim_way)
    );

    assign bus.hit_valid  = hit_valid_q;
    assign bus.hit_way    = hit_way_q;
    assign bus.hit_target = hit_target_q;
    assign bus.flush_busy = flush_busy_q;
endmodule

// File: tb/tb_btb_assoc.sv
// Self-checking bench for btb_assoc: directed vector table, flush/reset
// sequences and randomized traffic against a behavioural model.
module tb_btb_assoc;
    localparam int NS = 16;
    localparam int NW = 2;
    localparam int TW = 5;
    localparam int GW = 32;
    localparam int IW = $clog2(NS);

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    btb_assoc_if #(.NUM_SETS(NS), .NUM_WAYS(NW), .TAG_WIDTH(TW), .TARGET_WIDTH(GW)) bus ();

    btb_assoc #(.NUM_SETS(NS), .NUM_WAYS(NW), .TAG_WIDTH(TW), .TARGET_WIDTH(GW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Behavioural model: entries, round-robin pointers, LRU timestamps
    // (two-way tree PLRU is exact LRU), flush modelled as one bulk clear.
    bit          m_valid [NS][NW];
    int          m_tag   [NS][NW];
    logic [GW-1:0] m_tgt [NS][NW];
    int          m_rr    [NS];
    longint      m_use   [NS][NW];
    longint      stamp;
    int          busy_left;
    int          checks = 0;
    int          errors = 0;
    bit          e_hv;
    int          e_hw;
    logic [GW-1:0] e_ht;

    typedef struct {
        bit lv; int li; int lt;
        bit uv; int ui; int ut; logic [31:0] utg;
        bit fr;
        bit hv; int hw; logic [31:0] ht;
    } vec_t;
    vec_t tbl [18];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic model_clear();
        for (int s = 0; s < NS; s++) begin
            m_rr[s] = 0;
            for (int w = 0; w < NW; w++) begin
                m_valid[s][w] = 0;
                m_use[s][w]   = 0;
            end
        end
    endtask

    task automatic model_write(input int ui, input int ut, input logic [GW-1:0] utg);
        int way = -1;
        for (int w = 0; w < NW; w++) if (way < 0 && m_valid[ui][w] && m_tag[ui][w] == ut) way = w;
        for (int w = 0; w < NW; w++) if (way < 0 && !m_valid[ui][w]) way = w;
        if (way < 0) begin
`ifdef BTB_PLRU_EN
            way = 0;
            for (int w = 1; w < NW; w++) if (m_use[ui][w] < m_use[ui][way]) way = w;
`else
            way = m_rr[ui];
            m_rr[ui] = (m_rr[ui] + 1) % NW;
`endif
        end
        m_valid[ui][way] = 1;
        m_tag[ui][way]   = ut;
        m_tgt[ui][way]   = utg;
        stamp++;
        m_use[ui][way]   = stamp;
    endtask

    task automatic step(input bit lv, input int li, input int lt, input bit uv, input int ui,
                        input int ut, input logic [GW-1:0] utg, input bit fr);
        bus.lookup_valid = lv;
        bus.lookup_index = IW'(li);
        bus.lookup_tag   = TW'(lt);
        bus.upd_valid    = uv;
        bus.upd_index    = IW'(ui);
        bus.upd_tag      = TW'(ut);
        bus.upd_target   = utg;
        bus.flush_req    = fr;
        e_hv = 0; e_hw = 0; e_ht = '0;
        if (busy_left == 0 && lv)
            for (int w = 0; w < NW; w++)
                if (m_valid[li][w] && m_tag[li][w] == lt) begin
                    e_hv = 1; e_hw = w; e_ht = m_tgt[li][w];
                end
        if (busy_left > 0) busy_left--;
        else if (fr) begin
            model_clear();
            busy_left = NS;
        end else begin
            if (e_hv) begin stamp++; m_use[li][e_hw] = stamp; end
            if (uv) model_write(ui, ut, utg);
        end
        @(posedge clk);
        #1;
        chk("model_hit_valid", bus.hit_valid, e_hv);
        chk("model_hit_way", bus.hit_way, e_hw);
        chk("model_hit_target", bus.hit_target, e_ht);
        chk("model_flush_busy", bus.flush_busy, busy_left > 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "simulation did not finish");
    end

    initial begin
        int busy_cnt;
        // Directed vectors: one cycle each, expected result is the registered
        // output after that cycle's edge.
        tbl[0]  = '{1, 3, 5, 0, 0, 0, 32'h0,    0, 0, 0, 32'h0};
        tbl[1]  = '{0, 0, 0, 1, 3, 5, 32'h1000, 0, 0, 0, 32'h0};
        tbl[2]  = '{1, 3, 5, 0, 0, 0, 32'h0,    0, 1, 0, 32'h1000};
        tbl[3]  = '{1, 3, 5, 1, 3, 5, 32'h2000, 0, 1, 0, 32'h1000};
        tbl[4]  = '{1, 3, 5, 0, 0, 0, 32'h0,    0, 1, 0, 32'h2000};
        tbl[5]  = '{1, 3, 6, 1, 3, 6, 32'h3000, 0, 0, 0, 32'h0};
        tbl[6]  = '{1, 3, 6, 0, 0, 0, 32'h0,    0, 1, 1, 32'h3000};
        tbl[7]  = '{0, 0, 0, 1, 7, 1, 32'h71,   0, 0, 0, 32'h0};
        tbl[8]  = '{0, 0, 0, 1, 7, 2, 32'h72,   0, 0, 0, 32'h0};
        tbl[9]  = '{1, 7, 1, 0, 0, 0, 32'h0,    0, 1, 0, 32'h71};
        tbl[10] = '{0, 0, 0, 1, 7, 3, 32'h73,   0, 0, 0, 32'h0};
`ifdef BTB_PLRU_EN
        tbl[11] = '{1, 7, 1, 0, 0, 0, 32'h0,    0, 1, 0, 32'h71};
        tbl[12] = '{1, 7, 2, 0, 0, 0, 32'h0,    0, 0, 0, 32'h0};
        tbl[13] = '{1, 7, 3, 0, 0, 0, 32'h0,    0, 1, 1, 32'h73};
`else
        tbl[11] = '{1, 7, 1, 0, 0, 0, 32'h0,    0, 0, 0, 32'h0};
        tbl[12] = '{1, 7, 2, 0, 0, 0, 32'h0,    0, 1, 1, 32'h72};
        tbl[13] = '{1, 7, 3, 0, 0, 0, 32'h0,    0, 1, 0, 32'h73};
`endif
        tbl[14] = '{1, 4, 9, 1, 4, 9, 32'h49,   0, 0, 0, 32'h0};
        tbl[15] = '{1, 4, 9, 0, 0, 0, 32'h0,    0, 1, 0, 32'h49};
        tbl[16] = '{0, 0, 0, 1, 7, 4, 32'h74,   0, 0, 0, 32'h0};
`ifdef BTB_PLRU_EN
        tbl[17] = '{1, 7, 4, 0, 0, 0, 32'h0,    0, 1, 0, 32'h74};
`else
        tbl[17] = '{1, 7, 4, 0, 0, 0, 32'h0,    0, 1, 1, 32'h74};
`endif

        bus.lookup_valid = 0; bus.lookup_index = '0; bus.lookup_tag = '0;
        bus.upd_valid = 0; bus.upd_index = '0; bus.upd_tag = '0; bus.upd_target = '0;
        bus.flush_req = 0;
        model_clear();
        stamp = 0;
        busy_left = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_hit_valid", bus.hit_valid, 0);
        chk("reset_hit_way", bus.hit_way, 0);
        chk("reset_hit_target", bus.hit_target, 0);
        chk("reset_flush_busy", bus.flush_busy, 0);
        rst = 0;

        for (int i = 0; i < 18; i++) begin
            step(tbl[i].lv, tbl[i].li, tbl[i].lt, tbl[i].uv, tbl[i].ui, tbl[i].ut, tbl[i].utg, tbl[i].fr);
            chk($sformatf("vec%0d_hit_valid", i), bus.hit_valid, tbl[i].hv);
            chk($sformatf("vec%0d_hit_way", i), bus.hit_way, tbl[i].hw);
            chk($sformatf("vec%0d_hit_target", i), bus.hit_target, tbl[i].ht);
            $display("vec %0d: hit_valid=%0d hit_way=%0d hit_target=0x%0h", i,
                     bus.hit_valid, bus.hit_way, bus.hit_target);
        end

        // Full flush with concurrent update and a re-request while busy.
        for (int s = 0; s < NS; s++) step(0, 0, 0, 1, s, s + 8, 32'hA000 + s, 0);
        step(1, 2, 10, 1, 9, 30, 32'hDEAD, 1);
        chk("flush_pre_lookup_hit", bus.hit_valid, 1);
        chk("flush_busy_start", bus.flush_busy, 1);
        busy_cnt = 0;
        for (int c = 0; c < 3 * NS && bus.flush_busy; c++) begin
            busy_cnt++;
            step(1, c % NS, (c % NS) + 8, 1, c % NS, 1, 32'h5, c == 3);
            chk("flush_lookup_miss", bus.hit_valid, 0);
        end
        chk("flush_busy_cycles", busy_cnt, NS);
        $display("flush: busy for %0d cycles", busy_cnt);
        for (int s = 0; s < NS; s++) begin
            step(1, s, s + 8, 0, 0, 0, 32'h0, 0);
            chk("post_flush_miss", bus.hit_valid, 0);
        end
        step(1, 9, 30, 0, 0, 0, 32'h0, 0);
        chk("dropped_update_miss", bus.hit_valid, 0);

        // Reset while the flush is clearing set 5.
        for (int s = 0; s < NS; s++) step(0, 0, 0, 1, s, s + 8, 32'hB000 + s, 0);
        step(0, 0, 0, 0, 0, 0, 32'h0, 1);
        for (int c = 0; c < 5; c++) step(0, 0, 0, 0, 0, 0, 32'h0, 0);
        #2;
        rst = 1;
        #1;
        chk("rst_mid_flush_busy", bus.flush_busy, 0);
        chk("rst_mid_flush_hit_valid", bus.hit_valid, 0);
        model_clear();
        busy_left = 0;
        #1;
        rst = 0;
        for (int s = 0; s < NS; s++) begin
            step(1, s, s + 8, 0, 0, 0, 32'h0, 0);
            chk("post_rst_miss", bus.hit_valid, 0);
        end
        step(0, 0, 0, 1, 5, 3, 32'h55, 0);
        step(1, 5, 3, 0, 0, 0, 32'h0, 0);
        chk("post_rst_update_hit", bus.hit_valid, 1);
        chk("post_rst_update_target", bus.hit_target, 32'h55);
        $display("reset mid-flush: hit_valid=%0d hit_target=0x%0h", bus.hit_valid, bus.hit_target);

        // Randomized traffic on a few hot sets with few tags to force conflicts.
        for (int n = 0; n < 2000; n++) begin
            int li, ui;
            li = ($urandom_range(0, 3) == 0) ? $urandom_range(0, NS - 1) : $urandom_range(0, 3);
            ui = ($urandom_range(0, 3) == 0) ? $urandom_range(0, NS - 1) : $urandom_range(0, 3);
            step($urandom_range(0, 1), li, $urandom_range(0, 3), $urandom_range(0, 1), ui,
                 $urandom_range(0, 3), $urandom, $urandom_range(0, 149) == 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/btb_assoc.md
# btb_assoc

Parametrised set-associative branch target buffer for the fetch stage. Fetch presents a set index and tag each cycle and receives a registered hit/target one cycle later. Execute writes resolved taken branches through a separate update port. A multi-cycle flush sequencer invalidates the whole array on request. It succeeds the single-way BTB set with configurable associativity, victim replacement and duplicate suppression.

## Interface
- NUM_SETS, 16, number of sets (power of 2, ≥2)
- NUM_WAYS, 2, ways per set (power of 2, 1..8)
- TAG_WIDTH, 5, tag bits stored per entry
- TARGET_WIDTH, 32, branch target bits stored per entry
- IDX_W, $clog2(NUM_SETS), derived index width (localparam)
- WAY_W, max(1,$clog2(NUM_WAYS)), derived way-id width (localparam)

Ports:
- clk  in  1  clock; all state changes on posedge
- rst  in  1  asynchronous, active-high reset
- lookup_valid  in  1  fetch lookup request this cycle
- lookup_index  in  IDX_W  set to read
- lookup_tag  in  TAG_WIDTH  tag to compare
- hit_valid  out  1  registered: lookup of previous cycle hit
- hit_way  out  WAY_W  registered: way that hit (0 on miss)
- hit_target  out  TARGET_WIDTH  registered: target of hit way (0 on miss)
- upd_valid  in  1  write resolved branch
- upd_index  in  IDX_W  set to write
- upd_tag  in  TAG_WIDTH  tag to write
- upd_target  in  TARGET_WIDTH  target to write
- flush_req  in  1  start full invalidation (pulse or level)
- flush_busy  out  1  flush sequence in progress

## Operation
- Entry = {valid, tag, target}; one replacement state per set.
- Lookup: compare lookup_tag against all valid ways of lookup_index in parallel; at most one way matches (guaranteed by update rule). Result registered into hit_valid/hit_way/hit_target; miss drives hit_way=0, hit_target=0.
- Update way selection, priority order: (1) valid way with matching tag in upd_index → overwrite target, no duplicate; (2) lowest-numbered invalid way; (3) replacement victim. Written entry valid=1.
- Round-robin victim (default): per-set pointer; advances by 1 modulo NUM_WAYS only on allocation into case (3) victim.
- Flush FSM states IDLE, FLUSH. IDLE→FLUSH on flush_req with counter=0. FLUSH clears valid of all ways in set counter each cycle; counter+1; FLUSH→IDLE after set NUM_SETS-1 cleared. flush_busy=1 in FLUSH. Replacement state of each set reset to 0 as it is cleared.
- During FLUSH: lookups return miss; upd_valid ignored (dropped, not queued); flush_req ignored.
- Reset mid-flush: returns to IDLE, all valid cleared immediately.

## Timing
- Reset values: hit_valid=0, hit_way=0, hit_target=0, flush_busy=0, all valid=0, replacement state 0, FSM IDLE.
- Lookup latency 1 cycle; one lookup per cycle, fully pipelined.
- Update visible to lookups issued the cycle after upd_valid; same-cycle lookup and update to same set reads pre-update contents.
- flush_req sampled at cycle T: flush_busy=1 from T+1 through T+NUM_SETS; lookup issued at T already reads FLUSH-suppressed? No: lookup at T uses pre-flush array; lookups from T+1 to T+NUM_SETS miss.
- flush_req and upd_valid same cycle in IDLE: update dropped.
- Target width arbitrary; no arithmetic on targets.

## Configuration
- BTB_PLRU_EN defined: tree pseudo-LRU per set (NUM_WAYS-1 bits); updated toward the accessed way on every lookup hit and every update; victim = PLRU leaf. NUM_WAYS=1 degenerates to way 0.
- Undefined: round-robin pointer as above; lookup hits do not modify replacement state.

## Structure
- Package btb_pkg: localparam helpers for IDX_W/WAY_W, flush FSM state enum, entry struct typedef parameterless fields via width functions.
- One sub-module: btb_repl (per-set replacement state array, victim select, touch/alloc update), with PLRU/round-robin selected by BTB_PLRU_EN.

## Test plan
- Reset, lookup set 3 tag 5 → hit_valid=0, hit_way=0, hit_target=0 next cycle.
- Update set 3 tag 5 target 0x1000, then lookup set 3 tag 5 → hit_valid=1, hit_way=0, hit_target=0x1000; update same tag target 0x2000 → same way, target 0x2000, way 1 stays invalid.
- 2-way, fill set 7 with tags 1,2, then update tag 3: round-robin evicts way 0; PLRU with prior hit on tag 1 evicts way 1 (tag 2).
- Same-cycle update and lookup set 4 tag 9 on empty BTB → miss; lookup next cycle → hit.
- Fill all sets, pulse flush_req: flush_busy high exactly NUM_SETS cycles, concurrent update dropped, all lookups miss afterward.
- Assert rst mid-flush (set 5) → flush_busy=0 at once, all lookups miss, new update accepted next cycle.
